// File: rtl/usb_mouse_ps2_pkt.sv
// usb_mouse_ps2_pkt: decodes APF cont4 mouse reports into a clamped cursor and rate-limited PS/2 packets
module usb_mouse_ps2_pkt #(
  parameter int NUM_BTN     = 3,
  parameter int ACC_W       = 12,
  parameter int SCALE_SHIFT = 0,
  parameter int MIN_GAP     = 1000,
  parameter int POS_W       = 10,
  parameter int POS_X_MAX   = 319,
  parameter int POS_Y_MAX   = 239
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [31:0]               cont4_key,
  input  logic [31:0]               cont4_joy,
  input  logic [15:0]               cont4_trig,
  output logic                      is_mouse,
  output logic                      report_stb,
  output logic [NUM_BTN-1:0]        mouse_btn,
  output logic signed [15:0]        mouse_dx,
  output logic signed [15:0]        mouse_dy,
  output logic [POS_W-1:0]          mouse_x,
  output logic [POS_W-1:0]          mouse_y,
  output logic [24:0]               ps2_mouse
);
  localparam int EW = (ACC_W > 16 ? ACC_W : 16) + 2;
  localparam int PW = (POS_W > 16 ? POS_W : 16) + 2;
  localparam int GW = $clog2(MIN_GAP + 1);
  localparam logic signed [EW-1:0] A_MAX = EW'(2 ** (ACC_W - 1) - 1);
  localparam logic signed [EW-1:0] A_MIN = EW'(1 - 2 ** (ACC_W - 1));
  localparam logic signed [EW-1:0] O_MAX = EW'(255);
  localparam logic signed [EW-1:0] O_MIN = EW'(-256);
  localparam logic signed [EW-1:0] ZERO  = '0;
  localparam logic signed [PW-1:0] X_MAX = PW'(POS_X_MAX);
  localparam logic signed [PW-1:0] Y_MAX = PW'(POS_Y_MAX);
  typedef enum logic [1:0] {IDLE, EMIT, WAIT} state_t;
  state_t state;
  logic [2:0][3:0] typ_s;
  logic [2:0][15:0] cnt_s, dx_s, dy_s;
  logic [2:0][NUM_BTN-1:0] btn_s;
  logic [15:0] prev_cnt;
  logic signed [ACC_W-1:0] acc_x, acc_y;
  logic [2:0] last_btn, b3;
  logic [7:0] b8;
  logic [GW-1:0] gap;
  logic signed [EW-1:0] dxe, dye, sx, sy, axe, aye, oxe, oye, nx, ny;
  logic signed [PW-1:0] px, py;
  logic oxf, oyf, new_rpt, want;
  logic [7:0] status;
  logic unused_bits;
  function automatic logic signed [ACC_W-1:0] sat(input logic signed [EW-1:0] v);
    return ACC_W'(v > A_MAX ? A_MAX : v < A_MIN ? A_MIN : v);
  endfunction
  function automatic logic signed [EW-1:0] clip9(input logic signed [EW-1:0] v);
    return v > O_MAX ? O_MAX : v < O_MIN ? O_MIN : v;
  endfunction
  assign is_mouse    = typ_s[2] == 4'h5;
  assign new_rpt     = is_mouse && cnt_s[2] != prev_cnt;
  assign b8          = 8'(mouse_btn);
  assign b3          = b8[2:0];
  assign unused_bits = ^{cont4_key[27:16], cont4_joy[31:16], oxe, oye, b8};
  // Deltas are applied on the cycle after the report strobe, together with the packet drain.
  always_comb begin
    dxe    = EW'(mouse_dx);
    dye    = EW'(mouse_dy);
    sx     = report_stb ? (dxe >>> SCALE_SHIFT) : ZERO;
    sy     = report_stb ? -(dye >>> SCALE_SHIFT) : ZERO;
    axe    = EW'(acc_x);
    aye    = EW'(acc_y);
    oxe    = clip9(axe);
    oye    = clip9(aye);
    oxf    = oxe != axe;
    oyf    = oye != aye;
    nx     = axe - (state == EMIT ? oxe : ZERO) + sx;
    ny     = aye - (state == EMIT ? oye : ZERO) + sy;
    px     = PW'(signed'({1'b0, mouse_x})) + PW'(mouse_dx);
    py     = PW'(signed'({1'b0, mouse_y})) + PW'(mouse_dy);
    status = {oyf, oxf, oye[8], oxe[8], 1'b1, b3};
    want   = is_mouse && gap == '0 && (acc_x != '0 || acc_y != '0 || b3 != last_btn);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      typ_s      <= '0;
      cnt_s      <= '0;
      dx_s       <= '0;
      dy_s       <= '0;
      btn_s      <= '0;
      prev_cnt   <= '0;
      report_stb <= 1'b0;
      mouse_btn  <= '0;
      mouse_dx   <= '0;
      mouse_dy   <= '0;
      mouse_x    <= '0;
      mouse_y    <= '0;
      acc_x      <= '0;
      acc_y      <= '0;
      last_btn   <= '0;
      gap        <= '0;
      ps2_mouse  <= '0;
      state      <= IDLE;
    end else begin
      typ_s      <= {typ_s[1:0], cont4_key[31:28]};
      cnt_s      <= {cnt_s[1:0], cont4_key[7:0], cont4_key[15:8]};
      dx_s       <= {dx_s[1:0], cont4_joy[7:0], cont4_joy[15:8]};
      dy_s       <= {dy_s[1:0], cont4_trig[7:0], cont4_trig[15:8]};
      btn_s      <= {btn_s[1:0], cont4_joy[16 +: NUM_BTN]};
      prev_cnt   <= cnt_s[2];
      report_stb <= new_rpt;
      if (new_rpt) begin
        mouse_btn <= btn_s[2];
        mouse_dx  <= signed'(dx_s[2]);
        mouse_dy  <= signed'(dy_s[2]);
      end
      if (report_stb) begin
        mouse_x <= px[PW-1] ? '0 : px > X_MAX ? POS_W'(POS_X_MAX) : px[POS_W-1:0];
        mouse_y <= py[PW-1] ? '0 : py > Y_MAX ? POS_W'(POS_Y_MAX) : py[POS_W-1:0];
      end
      acc_x <= is_mouse ? sat(nx) : '0;
      acc_y <= is_mouse ? sat(ny) : '0;
      case (state)
        IDLE: if (want) state <= EMIT;
        EMIT: begin
          ps2_mouse <= {~ps2_mouse[24], oye[7:0], oxe[7:0], status};
          last_btn  <= b3;
          gap       <= GW'(MIN_GAP - 1);
          state     <= WAIT;
        end
        default: if (gap == '0) state <= IDLE; else gap <= gap - 1'b1;
      endcase
      if (!is_mouse) last_btn <= '0;
    end
  end
endmodule

// File: tb/tb_usb_mouse_ps2_pkt.sv
// tb_usb_mouse_ps2_pkt: directed vectors for the APF mouse to PS/2 packet decoder
module tb_usb_mouse_ps2_pkt;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [31:0] cont4_key = '0, cont4_joy = '0;
  logic [15:0] cont4_trig = '0;
  logic is_mouse, report_stb;
  logic [2:0] mouse_btn;
  logic signed [15:0] mouse_dx, mouse_dy;
  logic [9:0] mouse_x, mouse_y;
  logic [24:0] ps2_mouse;
  int n_vec = 0, n_err = 0;
  logic tog = 1'b0;
  logic [15:0] cnt = '0;
  always #5 clk = ~clk;
  usb_mouse_ps2_pkt dut (
    .clk(clk), .reset_n(reset_n), .cont4_key(cont4_key), .cont4_joy(cont4_joy),
    .cont4_trig(cont4_trig), .is_mouse(is_mouse), .report_stb(report_stb),
    .mouse_btn(mouse_btn), .mouse_dx(mouse_dx), .mouse_dy(mouse_dy),
    .mouse_x(mouse_x), .mouse_y(mouse_y), .ps2_mouse(ps2_mouse)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [15:0] dx, input logic [15:0] dy, input logic [7:0] btn);
    cont4_key  = {4'h5, 12'h0, cnt[7:0], cnt[15:8]};
    cont4_joy  = {8'h0, btn, dx[7:0], dx[15:8]};
    cont4_trig = {dy[7:0], dy[15:8]};
  endtask
  task automatic report(input string tag, input logic [15:0] dx, input logic [15:0] dy, input logic [7:0] btn);
    cnt++;
    drive(dx, dy, btn);
    for (int i = 0; i < 10 && !report_stb; i++) @(negedge clk);
    check({tag, "_stb"}, 32'(report_stb), 32'd1);
    @(negedge clk);
  endtask
  task automatic wait_pkt(input string tag, input logic [23:0] exp);
    for (int i = 0; i < 1500 && ps2_mouse[24] == tog; i++) @(negedge clk);
    tog = ~tog;
    check(tag, 32'(ps2_mouse), {7'h0, tog, exp});
  endtask
  task automatic no_pkt(input string tag, input int n);
    repeat (n) @(negedge clk);
    check(tag, 32'(ps2_mouse[24]), 32'(tog));
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_ps2", 32'(ps2_mouse), 32'd0);
    check("rst_stb", 32'(report_stb), 32'd0);
    check("rst_is_mouse", 32'(is_mouse), 32'd0);
    check("rst_x", 32'(mouse_x), 32'd0);
    reset_n   = 1'b1;
    cont4_key = 32'h5000_0000;
    repeat (5) @(negedge clk);
    check("type_is_mouse", 32'(is_mouse), 32'd1);
    check("idle_stb", 32'(report_stb), 32'd0);
    no_pkt("idle_quiet", 20);
    cnt = 16'd1;
    drive(16'd10, 16'd5, 8'h0);
    repeat (3) @(negedge clk);
    check("t1_stb_early", 32'(report_stb), 32'd0);
    @(negedge clk);
    check("t1_stb", 32'(report_stb), 32'd1);
    check("t1_dx", 32'(mouse_dx), 32'd10);
    check("t1_dy", 32'(mouse_dy), 32'd5);
    @(negedge clk);
    check("t1_stb_pulse", 32'(report_stb), 32'd0);
    check("t1_x", 32'(mouse_x), 32'd10);
    check("t1_y", 32'(mouse_y), 32'd5);
    wait_pkt("t1_pkt", 24'hFB0A28);
    no_pkt("t1_quiet", 50);
    report("t2", 16'd300, 16'd0, 8'h0);
    check("t2_x", 32'(mouse_x), 32'd310);
    wait_pkt("t2_pkt_ovf", 24'h00FF48);
    wait_pkt("t2_pkt_rest", 24'h002D08);
    no_pkt("t2_quiet", 1100);
    for (int k = 0; k < 50; k++) begin
      cnt++;
      drive(16'd100, 16'd0, 8'h0);
      repeat (2) @(negedge clk);
    end
    wait_pkt("t3_first", 24'h006408);
    for (int k = 0; k < 8; k++) wait_pkt("t3_sat", 24'h00FF48);
    wait_pkt("t3_tail", 24'h000708);
    no_pkt("t3_quiet", 1200);
    check("t3_x_clamp", 32'(mouse_x), 32'd319);
    report("p1", 16'hFFFC, 16'd0, 8'h0);
    check("p1_x", 32'(mouse_x), 32'd315);
    wait_pkt("p1_pkt", 24'h00FC18);
    report("p2", 16'd20, 16'd0, 8'h0);
    check("p2_x_max", 32'(mouse_x), 32'd319);
    wait_pkt("p2_pkt", 24'h001408);
    report("p3", 16'hFE70, 16'd0, 8'h0);
    check("p3_x_min", 32'(mouse_x), 32'd0);
    wait_pkt("p3_pkt_ovf", 24'h000058);
    wait_pkt("p3_pkt_rest", 24'h007018);
    report("b1", 16'd0, 16'd0, 8'h1);
    check("b1_btn", 32'(mouse_btn), 32'd1);
    wait_pkt("b1_press", 24'h000009);
    report("b2", 16'd0, 16'd0, 8'h0);
    wait_pkt("b2_release", 24'h000008);
    no_pkt("b2_no_repeat", 2500);
    report("r1", 16'd10, 16'd0, 8'h0);
    wait_pkt("r1_pkt", 24'h000A08);
    report("r2", 16'd50, 16'd0, 8'h0);
    check("r2_x", 32'(mouse_x), 32'd60);
    drive(16'd0, 16'd0, 8'h0);
    reset_n = 1'b0;
    @(negedge clk);
    check("r_ps2", 32'(ps2_mouse), 32'd0);
    check("r_x", 32'(mouse_x), 32'd0);
    check("r_dx", 32'(mouse_dx), 32'd0);
    check("r_stb", 32'(report_stb), 32'd0);
    check("r_is_mouse", 32'(is_mouse), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    tog = 1'b0;
    no_pkt("r_quiet", 1500);
    report("r3", 16'd3, 16'd0, 8'h0);
    wait_pkt("r3_pkt", 24'h000308);
    cont4_key = {4'h0, cont4_key[27:0]};
    repeat (4) @(negedge clk);
    check("type_off", 32'(is_mouse), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
